// File: rtl/moore_sequence_generator.sv
// Moore serial pattern transmitter: sends PAT MSB-first rep_cnt times, with optional idle gaps.
// Build option: define SEQ_GEN_OVERLAP_EN to let gap-less repetitions share the MSB/LSB bit.
module moore_sequence_generator #(
  parameter int                PAT_W = 4,
  parameter logic [PAT_W-1:0]  PAT   = 4'b1001,
  parameter int                REP_W = 4,
  parameter int                GAP_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [REP_W-1:0] rep_cnt,
  input  logic [GAP_W-1:0] gap,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);
`ifdef SEQ_GEN_OVERLAP_EN
  localparam logic [IDX_W-1:0] IDX_RELOAD = IDX_W'(PAT_W - 2);
`else
  localparam logic [IDX_W-1:0] IDX_RELOAD = IDX_TOP;
`endif

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [REP_W-1:0] rep_q;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gap_cnt_q;
  logic             x_q;
  logic             x_valid_q;
  logic             busy_q;
  logic             done_q;
  logic [IDX_W-1:0] idx_d;

  assign idx_d = idx_q - IDX_W'(1);

  // Outputs are registered alongside the state so each reflects the state being entered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      rep_q     <= '0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
      x_q       <= 1'b0;
      x_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      x_q       <= 1'b0;
      x_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            rep_q <= rep_cnt;
            gap_q <= gap;
            if (rep_cnt != '0) begin
              state_q   <= S_SEND;
              idx_q     <= IDX_TOP;
              x_q       <= PAT[IDX_TOP];
              x_valid_q <= 1'b1;
              busy_q    <= 1'b1;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        S_SEND: begin
          busy_q <= 1'b1;
          if (idx_q != '0) begin
            idx_q     <= idx_d;
            x_q       <= PAT[idx_d];
            x_valid_q <= 1'b1;
          end else if (rep_q > REP_W'(1)) begin
            rep_q <= rep_q - REP_W'(1);
            if (gap_q != '0) begin
              state_q   <= S_GAP;
              gap_cnt_q <= gap_q;
            end else begin
              idx_q     <= IDX_RELOAD;
              x_q       <= PAT[IDX_RELOAD];
              x_valid_q <= 1'b1;
            end
          end else begin
            rep_q   <= '0;
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_GAP: begin
          busy_q <= 1'b1;
          // The last gap cycle already launches the MSB of the next repetition.
          if (gap_cnt_q <= GAP_W'(1)) begin
            gap_cnt_q <= '0;
            state_q   <= S_SEND;
            idx_q     <= IDX_TOP;
            x_q       <= PAT[IDX_TOP];
            x_valid_q <= 1'b1;
          end else begin
            gap_cnt_q <= gap_cnt_q - GAP_W'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign x       = x_q;
  assign x_valid = x_valid_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
